manual_step_gen: RTL and testbench

//  Conditions the board's step pushbutton and mode switch into clean control inputs for the CPU clock controller.
//  - Outputs drive the controller's manual-clock and mode-select inputs.
//  - Synchronises and debounces both raw inputs.
//  - Produces a press-level manual clock, a one-cycle step pulse and a step count for the debug display.
//  - Sits in the top level, between the board I/O pins and clock_ctrl.

---
 rtl/manual_step_gen_pkg.sv | 27 ++
 rtl/debounce.sv | 46 ++++
 rtl/manual_step_gen.sv | 142 ++++++++++++++
 tb/tb_manual_step_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/manual_step_gen_pkg.sv
// Shared definitions for the step-button conditioner: FSM state encodings and default timing constants.
// The REPEAT encoding exists only when AUTO_REPEAT_EN is defined.
package manual_step_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1
`ifdef AUTO_REPEAT_EN
        ,
        ST_REPEAT  = 2'd2
`endif
    } btn_state_t;

    localparam logic [31:0] DEF_DEBOUNCE_CYCLES = 32'd500000;
    localparam logic [31:0] DEF_REPEAT_DELAY    = 32'd25000000;
    localparam logic [31:0] DEF_REPEAT_PERIOD   = 32'd5000000;

    // Cycles spent high in PRESSED before the repeat waveform takes over, chosen so the
    // first repeat rising edge lands REPEAT_DELAY cycles after the accepted press.
    function automatic logic [31:0] repeat_lead(input logic [31:0] delay, input logic [31:0] period);
        if (delay > period)
            return delay - period;
        else
            return 32'd1;
    endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stability counter; dout flips only after the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debounce
    import manual_step_gen_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic raw_clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic        sync_a;
    logic        sync_b;
    logic        stable;
    logic [31:0] count;

    always_ff @(posedge raw_clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
        end
    end

    // Any cycle of agreement restarts the count, so short glitches never reach the threshold.
    always_ff @(posedge raw_clk) begin
        if (rst) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sync_b == stable) begin
            count <= '0;
        end else if (count == DEBOUNCE_CYCLES - 32'd1) begin
            stable <= ~stable;
            count  <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign dout = stable;

endmodule

// File: rtl/manual_step_gen.sv
// Step pushbutton / mode switch conditioner feeding the CPU clock controller.
// Define AUTO_REPEAT_EN to enable hold-to-repeat stepping (adds REPEAT state and REPEAT_* parameters).
module manual_step_gen
    import manual_step_gen_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef AUTO_REPEAT_EN
    ,
    parameter logic [31:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter logic [31:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic        raw_clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic        mode_sw,
    output logic        manual_clk,
    output logic        auto_en,
    output logic        step_pulse,
    output logic [15:0] step_cnt
);

    logic       btn_db;
    logic       mode_db;
    btn_state_t state;
    btn_state_t next_state;
    logic       next_clk;
    logic       next_pulse;

`ifdef AUTO_REPEAT_EN
    localparam logic [31:0] REPEAT_LEAD = repeat_lead(REPEAT_DELAY, REPEAT_PERIOD);

    logic [31:0] hold_cnt;
    logic [31:0] period_cnt;
    logic [31:0] next_hold;
    logic [31:0] next_period;
`endif

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .raw_clk (raw_clk),
        .rst     (rst),
        .din     (btn_raw),
        .dout    (btn_db)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .raw_clk (raw_clk),
        .rst     (rst),
        .din     (mode_sw),
        .dout    (mode_db)
    );

    always_ff @(posedge raw_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            manual_clk <= 1'b0;
            step_pulse <= 1'b0;
            auto_en    <= 1'b0;
            step_cnt   <= '0;
`ifdef AUTO_REPEAT_EN
            hold_cnt   <= '0;
            period_cnt <= '0;
`endif
        end else begin
            state      <= next_state;
            manual_clk <= next_clk;
            step_pulse <= next_pulse;
            auto_en    <= mode_db;
            step_cnt   <= step_cnt + {15'd0, step_pulse};
`ifdef AUTO_REPEAT_EN
            hold_cnt   <= next_hold;
            period_cnt <= next_period;
`endif
        end
    end

    // Outputs are registered, so every decision here is one edge ahead of manual_clk.
    always_comb begin
        next_state  = state;
        next_clk    = manual_clk;
        next_pulse  = 1'b0;
`ifdef AUTO_REPEAT_EN
        next_hold   = hold_cnt;
        next_period = period_cnt;
`endif
        case (state)
            ST_IDLE: begin
                next_clk = 1'b0;
                if (btn_db && auto_en) begin
                    next_state = ST_PRESSED;
                    next_clk   = 1'b1;
                    next_pulse = 1'b1;
`ifdef AUTO_REPEAT_EN
                    next_hold  = '0;
`endif
                end
            end
            ST_PRESSED: begin
                next_clk = 1'b1;
                if (!btn_db) begin
                    next_state = ST_IDLE;
                    next_clk   = 1'b0;
                end
`ifdef AUTO_REPEAT_EN
                else if (hold_cnt == REPEAT_LEAD - 32'd1) begin
                    next_state  = ST_REPEAT;
                    next_clk    = 1'b0;
                    next_period = '0;
                end else begin
                    next_hold = hold_cnt + 32'd1;
                end
`endif
            end
`ifdef AUTO_REPEAT_EN
            ST_REPEAT: begin
                if (!btn_db) begin
                    next_state = ST_IDLE;
                    next_clk   = 1'b0;
                end else if (period_cnt == REPEAT_PERIOD - 32'd1) begin
                    next_clk    = ~manual_clk;
                    next_pulse  = ~manual_clk;
                    next_period = '0;
                end else begin
                    next_period = period_cnt + 32'd1;
                end
            end
`endif
            default: begin
                next_state = ST_IDLE;
                next_clk   = 1'b0;
            end
        endcase

        // Pass-through mode off overrides everything: the button is simply ignored.
        if (!auto_en) begin
            next_state = ST_IDLE;
            next_clk   = 1'b0;
            next_pulse = 1'b0;
        end
    end

endmodule

// File: tb/tb_manual_step_gen.sv
// Randomised scoreboard bench for manual_step_gen; define AUTO_REPEAT_EN to expect hold-to-repeat.
// A window-based reference model queues expected outputs per edge; a negedge monitor compares them.
module tb_manual_step_gen;

    localparam int N  = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic        raw_clk = 1'b0;
    logic        rst;
    logic        btn_raw;
    logic        mode_sw;
    logic        manual_clk;
    logic        auto_en;
    logic        step_pulse;
    logic [15:0] step_cnt;

    typedef struct packed {
        logic        mclk;
        logic        aen;
        logic        pulse;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   preload_req  = 0;
    int   preload_seen = 0;

    logic        btn_hist[$];
    logic        mode_hist[$];
    logic        m_btn_stb, m_mode_stb, m_aen, m_pressed, m_mclk, m_pulse;
    logic [15:0] m_cnt;
    int          m_age;
    logic        btn_old, mode_old, aen_old, mclk_old, pulse_old;

    always #5 raw_clk = ~raw_clk;

    manual_step_gen #(
        .DEBOUNCE_CYCLES (32'(N))
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (32'(RD)),
        .REPEAT_PERIOD   (32'(RP))
`endif
    ) dut (
        .raw_clk    (raw_clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .mode_sw    (mode_sw),
        .manual_clk (manual_clk),
        .auto_en    (auto_en),
        .step_pulse (step_pulse),
        .step_cnt   (step_cnt)
    );

    // A level is accepted once the N synchronised samples preceding the last one all disagree with it.
    function automatic logic windowDiffers(input logic h[$], input logic stb);
        if (h.size() < N) return 1'b0;
        for (int i = 0; i < N; i++)
            if (h[i] == stb) return 1'b0;
        return 1'b1;
    endfunction

    // manual_clk level as a function of cycles held since the accepted press.
    function automatic logic holdLevel(input int age);
`ifdef AUTO_REPEAT_EN
        if (age < RD - RP) return 1'b1;
        return (((age - (RD - RP)) / RP) % 2) == 1;
`else
        return (age >= 0);
`endif
    endfunction

    always @(posedge raw_clk) begin
        cycle++;
        if (rst) begin
            btn_hist.delete();
            mode_hist.delete();
            for (int i = 0; i <= N; i++) begin
                btn_hist.push_back(1'b0);
                mode_hist.push_back(1'b0);
            end
            m_btn_stb = 0; m_mode_stb = 0; m_aen = 0; m_pressed = 0;
            m_mclk = 0; m_pulse = 0; m_cnt = 16'h0000; m_age = 0;
            preload_seen = preload_req;
        end else begin
            btn_old = m_btn_stb; mode_old = m_mode_stb; aen_old = m_aen;
            mclk_old = m_mclk; pulse_old = m_pulse;
            if (preload_seen != preload_req) begin
                m_cnt = 16'hFFFF;
                preload_seen = preload_req;
            end
            if (windowDiffers(btn_hist, btn_old))   m_btn_stb  = ~btn_old;
            if (windowDiffers(mode_hist, mode_old)) m_mode_stb = ~mode_old;
            btn_hist.push_back(btn_raw);   btn_hist.delete(0);
            mode_hist.push_back(mode_sw);  mode_hist.delete(0);
            m_cnt = m_cnt + {15'd0, pulse_old};
            m_aen = mode_old;
            if (!aen_old) begin
                m_pressed = 0; m_mclk = 0;
            end else if (!m_pressed) begin
                if (btn_old) begin
                    m_pressed = 1; m_age = 0; m_mclk = 1;
                end else begin
                    m_mclk = 0;
                end
            end else if (!btn_old) begin
                m_pressed = 0; m_mclk = 0;
            end else begin
                m_age++;
                m_mclk = holdLevel(m_age);
            end
            m_pulse = m_mclk & ~mclk_old;
        end
        exp_q.push_back('{mclk: m_mclk, aen: m_aen, pulse: m_pulse, cnt: m_cnt});
    end

    task automatic checkOutput(input exp_t e);
        checks += 4;
        if (manual_clk !== e.mclk) begin
            errors++;
            $display("[TB] FAIL manual_clk cycle %0d: got %b expected %b", cycle, manual_clk, e.mclk);
        end
        if (auto_en !== e.aen) begin
            errors++;
            $display("[TB] FAIL auto_en cycle %0d: got %b expected %b", cycle, auto_en, e.aen);
        end
        if (step_pulse !== e.pulse) begin
            errors++;
            $display("[TB] FAIL step_pulse cycle %0d: got %b expected %b", cycle, step_pulse, e.pulse);
        end
        if (step_cnt !== e.cnt) begin
            errors++;
            $display("[TB] FAIL step_cnt cycle %0d: got %h expected %h", cycle, step_cnt, e.cnt);
        end
    endtask

    always @(negedge raw_clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    task automatic applyStimulus(input logic b, input logic m, input int cycles);
        btn_raw = b;
        mode_sw = m;
        repeat (cycles) @(negedge raw_clk);
    endtask

    task automatic preloadCount();
        @(negedge raw_clk);
        #1;
        force dut.step_cnt = 16'hFFFF;
        preload_req++;
        @(posedge raw_clk);
        #1;
        release dut.step_cnt;
    endtask

    initial begin
        rst = 1'b1; btn_raw = 1'b0; mode_sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_raw = i[0];
            mode_sw = ~i[0];
            @(negedge raw_clk);
        end
        rst = 1'b0;
        applyStimulus(0, 0, 5);

        $display("[TB] basic press with pass-through enabled");
        applyStimulus(0, 1, 10);
        applyStimulus(1, 1, 10);
        applyStimulus(0, 1, 12);

        $display("[TB] bouncing button");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 3);
            applyStimulus(0, 1, 3);
        end
        applyStimulus(0, 1, 10);

        $display("[TB] press while disabled, then enable while held");
        applyStimulus(0, 0, 12);
        applyStimulus(1, 0, 12);
        applyStimulus(1, 1, 15);
        applyStimulus(0, 1, 12);

        $display("[TB] long hold");
        applyStimulus(1, 1, 70);
        applyStimulus(0, 1, 12);

        $display("[TB] reset mid-press");
        applyStimulus(1, 1, 12);
        rst = 1'b1;
        applyStimulus(1, 1, 2);
        rst = 1'b0;
        applyStimulus(1, 1, 14);
        applyStimulus(0, 1, 12);

        $display("[TB] randomised segments");
        for (int s = 0; s < 300; s++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 70)) : int'($urandom_range(1, 14));
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), len);
        end

        $display("[TB] step counter wrap");
        applyStimulus(0, 1, 14);
        preloadCount();
        applyStimulus(0, 1, 3);
        applyStimulus(1, 1, 10);
        applyStimulus(0, 1, 12);

        repeat (3) @(negedge raw_clk);
        #1;
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected at most 1", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
